word_serializer: RTL

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 81 ++++++++
 1 files changed

// File: rtl/word_serializer.sv
// word_serializer: MSB-first parallel-to-serial converter with a modulo-256 frame counter; optional one-word prefetch buffer under SER_PREFETCH_EN
module word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             number,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             last,
  output logic [7:0]       frame_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sr, nxt_word;
  logic [CW-1:0] cnt;
  logic take, at_last, nxt_ok, do_load;
  assign take = in_valid && in_ready;
  assign at_last = state == SHIFT && cnt == CW'(WIDTH - 1);
`ifdef SER_PREFETCH_EN
  logic buf_full;
  logic [WIDTH-1:0] buf_data;
  assign in_ready = !buf_full;
  assign nxt_ok = buf_full || take;
  assign nxt_word = buf_full ? buf_data : in_data;
  // holding buffer captures a word offered mid-word and drains into the shifter at the last-bit edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (at_last) begin
      buf_full <= 1'b0;
    end else if (take && state == SHIFT) begin
      buf_full <= 1'b1;
      buf_data <= in_data;
    end
`else
  assign in_ready = state == IDLE;
  assign nxt_ok = take;
  assign nxt_word = in_data;
`endif
  assign do_load = (state == IDLE) ? take : (at_last && nxt_ok);
  assign number = sr[WIDTH-1];
  // shifter FSM: load a word, walk it out MSB first, then reload or fall back to idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      last        <= 1'b0;
    end else if (do_load) begin
      state       <= SHIFT;
      sr          <= nxt_word;
      cnt         <= '0;
      bit_valid   <= 1'b1;
      frame_start <= 1'b1;
      last        <= 1'b0;
    end else if (at_last) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      last        <= 1'b0;
    end else if (state == SHIFT) begin
      sr          <= sr << 1;
      cnt         <= cnt + 1'b1;
      frame_start <= 1'b0;
      last        <= cnt == CW'(WIDTH - 2);
    end
  // completed words counted at the edge that ends each last-bit cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (at_last) frame_cnt <= frame_cnt + 8'd1;
endmodule
